bram_port_arbiter: RTL and testbench

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

---
 rtl/bram_arb_pkg.sv | 31 +++
 rtl/arb_picker.sv | 59 +++++
 rtl/bram_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_bram_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared constants for the three-requester BRAM port arbiter.
//   Requester indices, lane bit positions, pipeline depth and the
//   arbiter control-state encoding.
package bram_arb_pkg;

  localparam int NUM_REQ   = 3;
  localparam int NUM_LANES = 3;
  localparam int STAGES    = 2;  // accept -> BRAM drive -> read data

  localparam int REQ_WB    = 0;  // outlier writeback
  localparam int REQ_CACHE = 1;  // cache fill
  localparam int REQ_FEED  = 2;  // feeder stream

  localparam int LANE_X = 0;
  localparam int LANE_Y = 1;
  localparam int LANE_Z = 2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } arb_state_e;

  // Index of the set bit in a one-hot (or zero) grant vector.
  function automatic logic [1:0] grant_idx(input logic [NUM_REQ-1:0] oh);
    if (oh[REQ_FEED])       return 2'(REQ_FEED);
    else if (oh[REQ_CACHE]) return 2'(REQ_CACHE);
    else                    return 2'(REQ_WB);
  endfunction

endpackage

// File: rtl/arb_picker.sv
// Grant selection for the BRAM port arbiter.
//   clock, reset : clock and synchronous active-high reset
//   req_valid    : per-requester request valid
//   grant_en     : grants may be issued this cycle
//   grant        : one-hot (or zero) grant, combinational
// Priority: starved feeder, then writeback, then cache/feeder round-robin.
module arb_picker
  import bram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               grant_en,
  output logic [NUM_REQ-1:0] grant
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q;
  logic             rr_feed_q;  // 1: feeder wins the next cache/feeder tie
  logic             starved;

  assign starved = (starve_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    grant = '0;
    if (grant_en) begin
      if (req_valid[REQ_FEED] && starved)
        grant[REQ_FEED] = 1'b1;
      else if (req_valid[REQ_WB])
        grant[REQ_WB] = 1'b1;
      else if (req_valid[REQ_CACHE] && req_valid[REQ_FEED])
        grant[rr_feed_q ? REQ_FEED : REQ_CACHE] = 1'b1;
      else if (req_valid[REQ_CACHE])
        grant[REQ_CACHE] = 1'b1;
      else if (req_valid[REQ_FEED])
        grant[REQ_FEED] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q  <= '0;
      rr_feed_q <= 1'b0;
    end else begin
      if (grant[REQ_CACHE])     rr_feed_q <= 1'b1;
      else if (grant[REQ_FEED]) rr_feed_q <= 1'b0;

      // Waiting is counted even while grants are held off.
      if (grant[REQ_FEED])
        starve_q <= '0;
      else if (req_valid[REQ_FEED] && !starved)
        starve_q <= starve_q + 1'b1;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Three-requester arbiter in front of a three-lane (x/y/z) BRAM.
//   clock, reset          : clock, synchronous active-high reset
//   req_*                 : per-requester valid/ready request channel
//   rsp_valid, rsp_data_* : read response, two cycles after accept
//   addr_*, write_in_*, read_out_*, en_*, rst_*, we_* : BRAM lane ports
//   hold_req / hold_ack   : stop granting / halted with pipeline empty
//   busy                  : an access is in the drive or read-data stage
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 128,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            req_valid,
  output logic [2:0]            req_ready,
  input  logic [2:0]            req_write,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [8:0]            req_lane,
  input  logic [3*DATA_W-1:0]   req_wdata,
  output logic [2:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_data_x,
  output logic [DATA_W-1:0]     rsp_data_y,
  output logic [DATA_W-1:0]     rsp_data_z,
  output logic [ADDR_W-1:0]     addr_x,
  output logic [ADDR_W-1:0]     addr_y,
  output logic [ADDR_W-1:0]     addr_z,
  output logic [DATA_W-1:0]     write_in_x,
  output logic [DATA_W-1:0]     write_in_y,
  output logic [DATA_W-1:0]     write_in_z,
  input  logic [DATA_W-1:0]     read_out_x,
  input  logic [DATA_W-1:0]     read_out_y,
  input  logic [DATA_W-1:0]     read_out_z,
  output logic                  en_x,
  output logic                  en_y,
  output logic                  en_z,
  output logic                  rst_x,
  output logic                  rst_y,
  output logic                  rst_z,
  output logic [DATA_W/8-1:0]   we_x,
  output logic [DATA_W/8-1:0]   we_y,
  output logic [DATA_W/8-1:0]   we_z,
  input  logic                  hold_req,
  output logic                  hold_ack,
  output logic                  busy
);

  localparam int WE_W = DATA_W / 8;

  arb_state_e state_q, state_d;

  logic [STAGES:1]                     vld_pipe;   // [1]: drive stage, [2]: read-data stage
  logic [NUM_REQ-1:0]                  rd_s1, rd_s2;
  logic [NUM_LANES-1:0]                en_q, we_q;
  logic [NUM_LANES-1:0][ADDR_W-1:0]    addr_q;
  logic [NUM_LANES-1:0][DATA_W-1:0]    wdata_q;

  logic                  grant_en, accept, sel_write;
  logic [NUM_REQ-1:0]    grant;
  logic [1:0]            sel;
  logic [NUM_LANES-1:0]  sel_lane;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;

  // hold_req gates grants combinationally so its first cycle already blocks.
  assign grant_en = (state_q == RUN) && !hold_req && !reset;

  arb_picker #(.STARVE_LIMIT(STARVE_LIMIT)) u_picker (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .grant_en  (grant_en),
    .grant     (grant)
  );

  assign accept    = |grant;
  assign sel       = grant_idx(grant);
  assign sel_lane  = req_lane[sel*NUM_LANES +: NUM_LANES];
  assign sel_write = req_write[sel];
  assign sel_addr  = req_addr[sel*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[sel*DATA_W +: DATA_W];

  // A zero lane mask still flows through the pipeline so reads respond.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      rd_s1    <= '0;
      rd_s2    <= '0;
      en_q     <= '0;
      we_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      rd_s1    <= (accept && !sel_write) ? grant : '0;
      rd_s2    <= rd_s1;
      en_q     <= accept ? sel_lane : '0;
      we_q     <= (accept && sel_write) ? sel_lane : '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        if (accept && sel_lane[l]) begin
          addr_q[l]  <= sel_addr;
          wdata_q[l] <= sel_wdata;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // DRAIN leaves once the drive stage is empty: whatever sits in the
  // read-data stage retires on the same edge, so HALTED sees no traffic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (hold_req) state_d = DRAIN;
      DRAIN:   if (!hold_req) state_d = RUN;
               else if (!vld_pipe[1]) state_d = HALTED;
      HALTED:  if (!hold_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Combinational outputs are masked during reset so every output reads 0.
  assign req_ready  = grant;
  assign rsp_valid  = reset ? '0 : rd_s2;
  assign rsp_data_x = reset ? '0 : read_out_x;
  assign rsp_data_y = reset ? '0 : read_out_y;
  assign rsp_data_z = reset ? '0 : read_out_z;
  assign hold_ack   = (state_q == HALTED) && !reset;
  assign busy       = (|vld_pipe) && !reset;

  assign addr_x     = addr_q[LANE_X];
  assign addr_y     = addr_q[LANE_Y];
  assign addr_z     = addr_q[LANE_Z];
  assign write_in_x = wdata_q[LANE_X];
  assign write_in_y = wdata_q[LANE_Y];
  assign write_in_z = wdata_q[LANE_Z];
  assign en_x       = en_q[LANE_X] && !reset;
  assign en_y       = en_q[LANE_Y] && !reset;
  assign en_z       = en_q[LANE_Z] && !reset;
  assign we_x       = {WE_W{we_q[LANE_X] && !reset}};
  assign we_y       = {WE_W{we_q[LANE_Y] && !reset}};
  assign we_z       = {WE_W{we_q[LANE_Z] && !reset}};
  assign rst_x      = 1'b0;
  assign rst_y      = 1'b0;
  assign rst_z      = 1'b0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: a driver issues directed and
// random requests, predicts grants and pushes expected BRAM drives and
// read responses; a negedge monitor pops and compares. A small BRAM
// model answers reads so response data is checked end to end.
module tb_bram_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 128;
  localparam int SL   = 15;
  localparam int WE_W = DW / 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [2:0]      req_valid, req_ready, req_write, rsp_valid;
  logic [3*AW-1:0] req_addr;
  logic [8:0]      req_lane;
  logic [3*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_data_x, rsp_data_y, rsp_data_z;
  logic [AW-1:0]   addr_x, addr_y, addr_z;
  logic [DW-1:0]   write_in_x, write_in_y, write_in_z;
  logic [DW-1:0]   read_out_x, read_out_y, read_out_z;
  logic            en_x, en_y, en_z, rst_x, rst_y, rst_z;
  logic [WE_W-1:0] we_x, we_y, we_z;
  logic            hold_req, hold_ack, busy;

  bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_lane(req_lane), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_data_x(rsp_data_x), .rsp_data_y(rsp_data_y), .rsp_data_z(rsp_data_z),
    .addr_x(addr_x), .addr_y(addr_y), .addr_z(addr_z),
    .write_in_x(write_in_x), .write_in_y(write_in_y), .write_in_z(write_in_z),
    .read_out_x(read_out_x), .read_out_y(read_out_y), .read_out_z(read_out_z),
    .en_x(en_x), .en_y(en_y), .en_z(en_z),
    .rst_x(rst_x), .rst_y(rst_y), .rst_z(rst_z),
    .we_x(we_x), .we_y(we_y), .we_z(we_z),
    .hold_req(hold_req), .hold_ack(hold_ack), .busy(busy)
  );

  wire [2:0]          en_a = {en_z, en_y, en_x};
  wire [3*WE_W-1:0]   we_a = {we_z, we_y, we_x};
  wire [2:0][AW-1:0]  ad_a = {addr_z, addr_y, addr_x};
  wire [2:0][DW-1:0]  wi_a = {write_in_z, write_in_y, write_in_x};
  wire [2:0][DW-1:0]  rd_a = {rsp_data_z, rsp_data_y, rsp_data_x};

  // BRAM model: 16 words per lane, read-first, one cycle read latency.
  logic [DW-1:0] bmem [3][16] = '{default: '0};
  logic [DW-1:0] rdo  [3]     = '{default: '0};
  assign read_out_x = rdo[0];
  assign read_out_y = rdo[1];
  assign read_out_z = rdo[2];
  always @(posedge clock)
    for (int l = 0; l < 3; l++)
      if (en_a[l]) begin
        if (we_a[l*WE_W +: WE_W] != '0) bmem[l][ad_a[l][3:0]] <= wi_a[l];
        rdo[l] <= bmem[l][ad_a[l][3:0]];
      end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model state.
  logic [DW-1:0] rmem [3][16] = '{default: '0};
  int unsigned starve = 0;
  bit  rr2    = 0;  // feeder wins the next cache/feeder tie
  int  mode   = 0;  // 0 running, 1 draining, 2 halted
  bit  acc_d1 = 0;  // an access was accepted one cycle ago
  bit  acc_d2 = 0;  // ... two cycles ago

  typedef struct { int cyc; logic [2:0] en; logic [2:0] we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } bram_exp_t;
  typedef struct { int cyc; logic [2:0] vld; logic [2:0] lane; logic [2:0][DW-1:0] data; } rsp_exp_t;
  bram_exp_t bq[$];
  rsp_exp_t  rq[$];

  logic [2:0]         s_w    = '0;
  logic [8:0]         s_lane = '0;
  logic [2:0][AW-1:0] s_addr = '0;
  logic [2:0][DW-1:0] s_data = '0;

  function automatic logic [2:0] pick(input logic [2:0] v, input logic h);
    if (mode != 0 || h)          return 3'b000;
    if (v[2] && starve == SL)    return 3'b100;
    if (v[0])                    return 3'b001;
    if (v[1] && v[2])            return rr2 ? 3'b100 : 3'b010;
    if (v[1])                    return 3'b010;
    if (v[2])                    return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [2:0] ln, input logic [DW-1:0] d);
    s_w[i] = w; s_addr[i] = a; s_lane[i*3 +: 3] = ln; s_data[i] = d;
  endtask

  // One cycle of stimulus; returns the DUT's grant for directed checks.
  task automatic step(input logic [2:0] v, input logic h, output logic [2:0] got);
    logic [2:0] g, ln;
    logic [3:0] a;
    int i;
    rsp_exp_t r;
    @(posedge clock); #1;
    req_valid = v; req_write = s_w; req_lane = s_lane;
    req_addr = s_addr; req_wdata = s_data; hold_req = h;
    #1;
    g = pick(v, h);
    got = req_ready;
    check("req_ready", req_ready, g);
    check("hold_ack", hold_ack, mode == 2);
    check("busy", busy, acc_d1 || acc_d2);
    if (g != 0) begin
      i  = g[2] ? 2 : (g[1] ? 1 : 0);
      ln = s_lane[i*3 +: 3];
      a  = s_addr[i][3:0];
      bq.push_back('{cyc + 1, ln, s_w[i] ? ln : 3'b000, s_addr[i], s_data[i]});
      if (s_w[i]) begin
        for (int l = 0; l < 3; l++) if (ln[l]) rmem[l][a] = s_data[i];
      end else begin
        r.cyc = cyc + 2; r.vld = g; r.lane = ln;
        for (int l = 0; l < 3; l++) r.data[l] = rmem[l][a];
        rq.push_back(r);
      end
    end
    if (g[2]) starve = 0;
    else if (v[2] && starve < SL) starve++;
    if (g[1]) rr2 = 1;
    else if (g[2]) rr2 = 0;
    case (mode)
      0: if (h) mode = 1;
      1: if (!h) mode = 0; else if (!acc_d1) mode = 2;
      default: if (!h) mode = 0;
    endcase
    acc_d2 = acc_d1;
    acc_d1 = (g != 0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clock); #1;
    reset = 1'b1; req_valid = '0; hold_req = 1'b0;
    bq.delete(); rq.delete();
    mode = 0; starve = 0; rr2 = 0; acc_d1 = 0; acc_d2 = 0;
    repeat (n) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  bram_exp_t mb;
  rsp_exp_t  mr;
  logic [2:0] xe, xw, xv;

  always @(negedge clock) begin
    check("rst_tied_low", {rst_z, rst_y, rst_x}, 3'b000);
    if (reset) begin
      check("reset_outputs", {req_ready, rsp_valid, en_a, we_a, hold_ack, busy}, '0);
    end else begin
      xe = '0; xw = '0; xv = '0;
      if (bq.size() != 0 && bq[0].cyc == cyc) begin
        mb = bq.pop_front();
        xe = mb.en; xw = mb.we;
        for (int l = 0; l < 3; l++) begin
          if (mb.en[l]) check("addr", ad_a[l], mb.addr);
          if (mb.we[l]) check("write_in", wi_a[l], mb.wdata);
        end
      end
      check("en", en_a, xe);
      check("we", we_a, {{WE_W{xw[2]}}, {WE_W{xw[1]}}, {WE_W{xw[0]}}});
      if (rq.size() != 0 && rq[0].cyc == cyc) begin
        mr = rq.pop_front();
        xv = mr.vld;
        for (int l = 0; l < 3; l++) if (mr.lane[l]) check("rsp_data", rd_a[l], mr.data[l]);
      end
      check("rsp_valid", rsp_valid, xv);
    end
  end

  initial begin
    logic [2:0] g;
    logic h;
    req_valid = '0; req_write = '0; req_lane = '0;
    req_addr = '0; req_wdata = '0; hold_req = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Single read on the cache requester.
    set_req(1, 1'b0, 32'h20, 3'b111, '0);
    step(3'b010, 1'b0, g); check("single_read_grant", g, 3'b010);
    repeat (3) step(3'b000, 1'b0, g);

    // Writeback write to lane z only.
    set_req(0, 1'b1, 32'h7, 3'b100, '0);
    step(3'b001, 1'b0, g); check("lane_mask_grant", g, 3'b001);
    repeat (3) step(3'b000, 1'b0, g);

    // Contention: writeback dominates, then cache/feeder alternate.
    do_reset(1);
    for (int i = 0; i < 3; i++)
      set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), rnd_data());
    for (int k = 0; k < 6; k++) begin
      step(3'b111, 1'b0, g); check("contention_wb", g, 3'b001);
    end
    for (int k = 0; k < 4; k++) begin
      step(3'b110, 1'b0, g); check("contention_rr", g, (k % 2 == 0) ? 3'b010 : 3'b100);
    end

    // Starvation: feeder forced every 16th cycle against constant writeback.
    repeat (2) step(3'b000, 1'b0, g);
    do_reset(1);
    for (int k = 0; k < 32; k++) begin
      step(3'b101, 1'b0, g); check("starve_grant", g, (k == 15 || k == 31) ? 3'b100 : 3'b001);
    end

    // Hold handshake around an in-flight read.
    repeat (2) step(3'b000, 1'b0, g);
    set_req(1, 1'b0, 32'h5, 3'b011, '0);
    step(3'b010, 1'b0, g); check("hold_pre_grant", g, 3'b010);
    step(3'b010, 1'b1, g); check("hold_first_cycle", g, 3'b000);
    step(3'b010, 1'b1, g); check("hold_drain", g, 3'b000);
    step(3'b010, 1'b1, g); check("hold_halted", g, 3'b000);
    check("hold_ack_halted", hold_ack, 1'b1);
    step(3'b010, 1'b0, g); check("hold_release", g, 3'b000);
    step(3'b010, 1'b0, g); check("hold_resume", g, 3'b010);

    // Reset right after an accepted read suppresses its drive and response.
    step(3'b000, 1'b0, g);
    set_req(2, 1'b0, 32'h3, 3'b111, '0);
    step(3'b100, 1'b0, g); check("pre_reset_grant", g, 3'b100);
    do_reset(1);

    // Random traffic with holds and occasional resets.
    h = 1'b0;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 3; i++)
        set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), rnd_data());
      if ($urandom_range(0, 15) == 0) h = ~h;
      if ($urandom_range(0, 199) == 0) begin
        step(3'b000, h, g);
        do_reset(2);
        h = 1'b0;
      end else begin
        step(3'($urandom_range(0, 7)), h, g);
      end
    end

    repeat (4) step(3'b000, 1'b0, g);
    check("scoreboard_drained", bq.size() + rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
